// File: rtl/modcnt_pkg.sv
// Shared encodings for the modulo up/down counter FSM: run modes and controller states.
package modcnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/modcnt_prescaler.sv
// Step prescaler for mod_counter_fsm: emits one step_tick per PRESCALE enabled cycles.
// Only instantiated when MODCNT_PRESCALE_EN is defined.
module modcnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step_tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = step_tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_counter_fsm.sv
// Modulo up/down counter sequenced by an IDLE/RUN/HOLD state machine, with a registered tc pulse.
// Define MODCNT_PRESCALE_EN to step only once every PRESCALE enabled RUN cycles.
module mod_counter_fsm
  import modcnt_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4
`ifdef MODCNT_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             run_en;
  logic             step;
  logic             at_term;

  assign run_en  = (state_q == ST_RUN) && enable;
  assign at_term = up_dn ? (count_q == MAX_VAL) : (count_q == '0);

`ifdef MODCNT_PRESCALE_EN
  logic step_tick;
  logic presc_clear;

  // Load and stop outrank stepping, and entering RUN restarts the step phase.
  assign presc_clear = load || stop || ((state_q == ST_IDLE) && start);

  modcnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable    (run_en),
    .clear     (presc_clear),
    .step_tick (step_tick)
  );

  assign step = step_tick;
`else
  assign step = run_en;
`endif

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;

    if (load) begin
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
      if (state_q == ST_HOLD) state_d = ST_RUN;
    end else if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (step) begin
            if (!at_term) begin
              count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              case (mode_e'(mode))
                MODE_SAT: state_d = ST_HOLD;
                MODE_ONESHOT: begin
                  count_d = up_dn ? '0 : MAX_VAL;
                  state_d = ST_IDLE;
                end
                default: count_d = up_dn ? '0 : MAX_VAL;
              endcase
            end
          end
        end
        ST_HOLD: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_mod_counter_fsm.sv
// Directed self-checking bench for mod_counter_fsm: modulus-4 and modulus-5 instances share stimulus.
module tb_mod_counter_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       enable = 1'b0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] a_count, b_count;
  logic       a_tc, b_tc, a_busy, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef MODCNT_PRESCALE_EN
  logic [2:0] c_count;
  logic       c_tc, c_busy;

  mod_counter_fsm #(.WIDTH(3), .MODULUS(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_val(load_val), .count(a_count), .tc(a_tc), .busy(a_busy));
  mod_counter_fsm #(.WIDTH(3), .MODULUS(5), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_val(load_val), .count(b_count), .tc(b_tc), .busy(b_busy));
  mod_counter_fsm #(.WIDTH(3), .MODULUS(4), .PRESCALE(3)) dut_c (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_val(load_val), .count(c_count), .tc(c_tc), .busy(c_busy));
`else
  mod_counter_fsm #(.WIDTH(3), .MODULUS(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_val(load_val), .count(a_count), .tc(a_tc), .busy(a_busy));
  mod_counter_fsm #(.WIDTH(3), .MODULUS(5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_val(load_val), .count(b_count), .tc(b_tc), .busy(b_busy));
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int cnt, input int t, input int b);
    check({tag, "_a_count"}, a_count, cnt);
    check({tag, "_a_tc"}, a_tc, t);
    check({tag, "_a_busy"}, a_busy, b);
  endtask

  task automatic check_b(input string tag, input int cnt, input int t, input int b);
    check({tag, "_b_count"}, b_count, cnt);
    check({tag, "_b_tc"}, b_tc, t);
    check({tag, "_b_busy"}, b_busy, b);
  endtask

  int t1_cnt[5] = '{1, 2, 3, 0, 1};
  int t1_tc[5]  = '{0, 0, 0, 1, 0};
  int t2_cnt[4] = '{1, 0, 0, 0};
  int t2_tc[4]  = '{0, 0, 1, 0};
  int t3_cnt[7] = '{1, 2, 3, 4, 0, 0, 0};
  int t3_tc[7]  = '{0, 0, 0, 0, 1, 0, 0};
  int t3_bsy[7] = '{1, 1, 1, 1, 0, 0, 0};
`ifdef MODCNT_PRESCALE_EN
  int t6_en[8]  = '{1, 1, 1, 1, 1, 0, 0, 1};
  int t6_cnt[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
`endif

  initial begin
    #1;
    check_a("reset", 0, 0, 0);
    #1 reset = 1'b0;

    // Wrap mode, counting up through the modulus.
    start = 1'b1; mode = 2'd0; up_dn = 1'b1; enable = 1'b1;
    step_clk();
    check_a("wrap_start", 0, 0, 1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check_a($sformatf("wrap_%0d", i), t1_cnt[i], t1_tc[i], 1);
    end
    stop = 1'b1;
    step_clk();
    check_a("stop", 1, 0, 0);
    stop = 1'b0;

    // Saturate mode counting down from a loaded value, then reload out of HOLD.
    mode = 2'd1; up_dn = 1'b0; load = 1'b1; load_val = 3'd2;
    step_clk();
    check_a("sat_load_idle", 2, 0, 0);
    load = 1'b0; start = 1'b1;
    step_clk();
    check_a("sat_start", 2, 0, 1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      check_a($sformatf("sat_%0d", i), t2_cnt[i], t2_tc[i], 1);
    end
    load = 1'b1; load_val = 3'd3;
    step_clk();
    check_a("sat_reload", 3, 0, 1);
    load = 1'b0;
    step_clk();
    check_a("sat_resume0", 2, 0, 1);
    step_clk();
    check_a("sat_resume1", 1, 0, 1);

    // Park both instances in IDLE at zero.
    load = 1'b1; load_val = 3'd0;
    step_clk();
    load = 1'b0; stop = 1'b1;
    step_clk();
    stop = 1'b0;
    check_b("park", 0, 0, 0);

    // One-shot on the modulus-5 instance.
    mode = 2'd2; up_dn = 1'b1; start = 1'b1; enable = 1'b1;
    step_clk();
    check_b("oneshot_start", 0, 0, 1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step_clk();
      check_b($sformatf("oneshot_%0d", i), t3_cnt[i], t3_tc[i], t3_bsy[i]);
    end

    // Out-of-range load clamps, and load outranks a simultaneous stop.
    enable = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0; load = 1'b1; stop = 1'b1; load_val = 3'd7;
    step_clk();
    check_a("clamp", 3, 0, 1);
    check_b("clamp", 4, 0, 1);
    load = 1'b0; stop = 1'b0; mode = 2'd0; up_dn = 1'b1; enable = 1'b1;
    step_clk();
    check_a("after_clamp", 0, 1, 1);
    check_b("after_clamp", 0, 1, 1);

    // Asynchronous reset between edges.
    step_clk();
    step_clk();
    check_a("pre_reset", 2, 0, 1);
    #3 reset = 1'b1;
    #1;
    check_a("async_reset", 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    step_clk();
    check_a("restart", 0, 0, 1);
    start = 1'b0;
    step_clk();
    check_a("restart_step", 1, 0, 1);

`ifdef MODCNT_PRESCALE_EN
    // Prescaler of 3: gaps keep the phase, stop and restart clear it.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; mode = 2'd0; up_dn = 1'b1; start = 1'b1;
    step_clk();
    check("presc_start_busy", c_busy, 1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enable = t6_en[i][0];
      step_clk();
      check($sformatf("presc_%0d", i), c_count, t6_cnt[i]);
    end
    enable = 1'b1;
    step_clk();
    stop = 1'b1;
    step_clk();
    check("presc_stop_busy", c_busy, 0);
    check("presc_stop_count", c_count, 2);
    stop = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    step_clk();
    check("presc_after_stop0", c_count, 2);
    step_clk();
    check("presc_after_stop1", c_count, 2);
    step_clk();
    check("presc_after_stop2", c_count, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
